// File: rtl/bitwise_pkg.sv
// Shared types for the bitwise operation stage: opcode and skid-buffer state encodings.
package bitwise_pkg;

    typedef enum logic [1:0] {
        BW_AND  = 2'b00,
        BW_OR   = 2'b01,
        BW_NAND = 2'b10,
        BW_NOR  = 2'b11
    } bitwise_op_e;

    localparam int unsigned BW_NUM_OPS = 4;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_e;

endpackage

// File: rtl/bitwise_skid_buf.sv
// Two-entry valid/ready skid buffer; head entry drives the outputs and in_ready is registered
// so no combinational path exists from out_ready back to in_ready.
module bitwise_skid_buf
    import bitwise_pkg::*;
#(
    parameter int unsigned DW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    buf_state_e    r_state;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [DW-1:0] r_head;
    logic [DW-1:0] r_skid;

    logic w_in_xfer;
    logic w_out_xfer;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= BUF_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head      <= '0;
            r_skid      <= '0;
        end else begin
            unique case (r_state)
                BUF_EMPTY: begin
                    if (w_in_xfer) begin
                        r_head      <= in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        r_skid     <= in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= BUF_TWO;
                    end else if (!w_in_xfer && w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= BUF_EMPTY;
                    end else if (w_in_xfer && w_out_xfer) begin
                        r_head <= in_data;
                    end
                end
                BUF_TWO: begin
                    // in_ready is low here, so only a drain can happen
                    if (w_out_xfer) begin
                        r_head     <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= BUF_ONE;
                    end
                end
                default: begin
                    r_state     <= BUF_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head;

endmodule

// File: rtl/bitwise_op_stage.sv
// Handshaked AND/OR/NAND/NOR stage with zero/all-ones flags behind a 2-entry skid buffer.
// Optional per-op saturating accept counters when BITWISE_OP_COUNT_EN is defined.
module bitwise_op_stage
    import bitwise_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones
`ifdef BITWISE_OP_COUNT_EN
    ,
    output logic [BW_NUM_OPS*CNT_WIDTH-1:0] op_count
`endif
);

    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             w_ones;
    logic [WIDTH+1:0] w_buf_in;
    logic [WIDTH+1:0] w_buf_out;

    always_comb begin
        w_result = '0;
        unique case (bitwise_op_e'(in_op))
            BW_AND:  w_result = in_a & in_b;
            BW_OR:   w_result = in_a | in_b;
            BW_NAND: w_result = ~(in_a & in_b);
            BW_NOR:  w_result = ~(in_a | in_b);
            default: w_result = '0;
        endcase
    end

    assign w_zero   = (w_result == '0);
    assign w_ones   = &w_result;
    assign w_buf_in = {w_result, w_zero, w_ones};

    bitwise_skid_buf #(
        .DW(WIDTH + 2)
    ) u_skid_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (w_buf_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_buf_out)
    );

    assign out_result = w_buf_out[WIDTH+1:2];
    assign out_zero   = w_buf_out[1];
    assign out_ones   = w_buf_out[0];

`ifdef BITWISE_OP_COUNT_EN
    logic                 w_in_xfer;
    logic [CNT_WIDTH-1:0] r_op_count [BW_NUM_OPS];

    assign w_in_xfer = in_valid & in_ready;

    // Counters saturate at all ones rather than wrapping
    always_ff @(posedge clk) begin
        for (int k = 0; k < BW_NUM_OPS; k++) begin
            if (rst) begin
                r_op_count[k] <= '0;
            end else if (w_in_xfer && (in_op == 2'(k)) && (r_op_count[k] != '1)) begin
                r_op_count[k] <= r_op_count[k] + CNT_WIDTH'(1);
            end
        end
    end

    assign op_count = {r_op_count[3], r_op_count[2], r_op_count[1], r_op_count[0]};
`endif

endmodule

// File: tb/tb_bitwise_op_stage.sv
// Self-checking bench for bitwise_op_stage: directed op/flag cases, backpressure, random
// scoreboard run, mid-operation reset and (with BITWISE_OP_COUNT_EN) counter saturation.
module tb_bitwise_op_stage;

    localparam int W  = 8;
    localparam int CW = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero;
    logic         out_ones;
`ifdef BITWISE_OP_COUNT_EN
    logic [4*CW-1:0] op_count;
`endif

    always #5 clk = ~clk;

    bitwise_op_stage #(
        .WIDTH    (W),
        .CNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_zero  (out_zero),
        .out_ones  (out_ones)
`ifdef BITWISE_OP_COUNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         o;
    } beat_t;

    beat_t q[$];
    beat_t head;
    int    cnt[4];
    int    checks = 0;
    int    errors = 0;
    int    pops   = 0;

    function automatic beat_t ref_beat(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
        beat_t r;
        case (op)
            2'd0:    r.res = a & b;
            2'd1:    r.res = a | b;
            2'd2:    r.res = ~(a & b);
            default: r.res = ~(a | b);
        endcase
        r.z = (r.res == '0);
        r.o = (r.res == {W{1'b1}});
        return r;
    endfunction

    // Advance one clock and update the queue model; acc reports whether the beat was accepted
    task automatic tick(output bit acc);
        bit ix;
        bit ox;
        ix = in_valid && (q.size() < 2);
        ox = out_ready && (q.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            head = '0;
            for (int k = 0; k < 4; k++) cnt[k] = 0;
            acc = 1'b0;
        end else begin
            if (ox) begin
                void'(q.pop_front());
                pops++;
            end
            if (ix) begin
                q.push_back(ref_beat(in_a, in_b, in_op));
                if (cnt[in_op] < (1 << CW) - 1) cnt[in_op]++;
            end
            if (q.size() > 0) head = q[0];
            acc = ix;
        end
    endtask

    task automatic test_reset();
        bit acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = 2'd0;
        tick(acc);
        tick(acc);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0 ||
            out_zero !== 1'b0 || out_ones !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b res=%h z=%b o=%b, need 0 1 00 0 0",
                     out_valid, in_ready, out_result, out_zero, out_ones);
        end
    endtask

    task automatic test_ops();
        bit acc;
        logic [W-1:0] exp_res [4];
        exp_res[0] = 8'h30; exp_res[1] = 8'hFC; exp_res[2] = 8'hCF; exp_res[3] = 8'h03;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_a = 8'hF0; in_b = 8'h3C; in_op = 2'(k);
            tick(acc);
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_res[k] || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL op%0d: valid=%b res=%h ready=%b, need 1 %h 1",
                         k, out_valid, out_result, in_ready, exp_res[k]);
            end
        end
        in_valid = 1'b0;
        tick(acc);
        checks++;
        if (out_valid !== 1'b0 || out_result !== 8'h03) begin
            errors++;
            $display("FAIL ops_idle: valid=%b res=%h, need 0 03", out_valid, out_result);
        end
    endtask

    task automatic test_flags();
        bit acc;
        logic [1:0]   ops  [3];
        logic [W-1:0] eres [3];
        logic [1:0]   eflg [3];
        ops[0] = 2'd0; eres[0] = 8'h00; eflg[0] = 2'b10;
        ops[1] = 2'd1; eres[1] = 8'hFF; eflg[1] = 2'b01;
        ops[2] = 2'd3; eres[2] = 8'h00; eflg[2] = 2'b10;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_a = 8'h0F; in_b = 8'hF0; in_op = ops[k];
            tick(acc);
            checks++;
            if (out_valid !== 1'b1 || out_result !== eres[k] ||
                {out_zero, out_ones} !== eflg[k]) begin
                errors++;
                $display("FAIL flags%0d: res=%h zo=%b%b, need %h %b",
                         k, out_result, out_zero, out_ones, eres[k], eflg[k]);
            end
        end
        in_valid = 1'b0;
        tick(acc);
    endtask

    task automatic test_backpressure();
        bit acc;
        beat_t b [3];
        int    got;
        for (int k = 0; k < 3; k++) b[k] = ref_beat(W'(8'h11 * (k + 1)), 8'hA5, 2'(k));
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'hA5; in_op = 2'd0;
        tick(acc);
        in_a = 8'h22; in_op = 2'd1;
        tick(acc);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== b[0].res) begin
            errors++;
            $display("FAIL bp_full: ready=%b valid=%b res=%h, need 0 1 %h",
                     in_ready, out_valid, out_result, b[0].res);
        end
        in_a = 8'h33; in_op = 2'd2;
        for (int c = 0; c < 3; c++) begin
            tick(acc);
            checks++;
            if (acc || in_ready !== 1'b0 || out_result !== b[0].res) begin
                errors++;
                $display("FAIL bp_hold: acc=%b ready=%b res=%h, need 0 0 %h",
                         acc, in_ready, out_result, b[0].res);
            end
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8 && got < 3; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (out_result !== b[got].res) begin
                    errors++;
                    $display("FAIL bp_order%0d: res=%h, need %h", got, out_result, b[got].res);
                end
                got++;
            end
            tick(acc);
            if (acc) in_valid = 1'b0;
        end
        checks++;
        if (got != 3) begin
            errors++;
            $display("FAIL bp_count: got=%0d, need 3", got);
        end
    endtask

    task automatic test_random();
        bit           acc;
        int           accepted;
        int           pops0;
        bit           stalled;
        logic [W+1:0] prev;
        accepted = 0;
        pops0    = pops;
        in_valid = 1'b1;
        in_a = W'($urandom); in_b = W'($urandom); in_op = 2'($urandom);
        for (int c = 0; c < 2000 && accepted < 200; c++) begin
            out_ready = c[0];
            stalled   = out_valid && !out_ready;
            prev      = {out_result, out_zero, out_ones};
            tick(acc);
            if (acc) begin
                accepted++;
                in_a = W'($urandom); in_b = W'($urandom); in_op = 2'($urandom);
            end
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
                {out_result, out_zero, out_ones} !== {head.res, head.z, head.o}) begin
                errors++;
                $display("FAIL rand: v=%b r=%b out=%h/%b%b, need %b %b %h/%b%b",
                         out_valid, in_ready, out_result, out_zero, out_ones,
                         q.size() > 0, q.size() < 2, head.res, head.z, head.o);
            end
            if (stalled) begin
                checks++;
                if ({out_result, out_zero, out_ones} !== prev) begin
                    errors++;
                    $display("FAIL stall_hold: out=%h, need %h",
                             {out_result, out_zero, out_ones}, prev);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick(acc);
        checks++;
        if (accepted != 200 || pops - pops0 != 200 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_total: acc=%0d pops=%0d valid=%b, need 200 200 0",
                     accepted, pops - pops0, out_valid);
        end
`ifdef BITWISE_OP_COUNT_EN
        checks++;
        if (op_count !== {CW'(cnt[3]), CW'(cnt[2]), CW'(cnt[1]), CW'(cnt[0])}) begin
            errors++;
            $display("FAIL rand_count: op_count=%h, need %0d/%0d/%0d/%0d",
                     op_count, cnt[3], cnt[2], cnt[1], cnt[0]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit acc;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h0F; in_op = 2'd1;
        tick(acc);
        tick(acc);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill: ready=%b valid=%b, need 0 1", in_ready, out_valid);
        end
        rst = 1'b1; in_valid = 1'b0;
        tick(acc);
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0 ||
                out_zero !== 1'b0 || out_ones !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset%0d: v=%b r=%b res=%h z=%b o=%b, need 0 1 00 0 0",
                         c, out_valid, in_ready, out_result, out_zero, out_ones);
            end
            tick(acc);
        end
    endtask

    task automatic test_count();
        bit acc;
        rst = 1'b1; in_valid = 1'b0;
        tick(acc);
        rst = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_op = 2'd0;
            tick(acc);
        end
        in_valid = 1'b0;
        tick(acc);
        checks++;
        if (out_valid !== 1'b0 || cnt[0] != 3) begin
            errors++;
            $display("FAIL count_drain: valid=%b model=%0d, need 0 3", out_valid, cnt[0]);
        end
`ifdef BITWISE_OP_COUNT_EN
        checks++;
        if (op_count !== 8'b00_00_00_11) begin
            errors++;
            $display("FAIL count_sat: op_count=%b, need 00000011", op_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ops();
        test_flags();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
